// File: rtl/gray_decoder.sv
// Two-stage pipelined Gray-to-binary decoder with an optional step checker that is
// built only when GRAY_DEC_STEP_CHECK_EN is defined.
module gray_decoder #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    input  logic             clr_err,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    output logic             dir_up,
    output logic             dir_dn,
    output logic             step_err,
    output logic [ERR_W-1:0] err_cnt
);

    logic [WIDTH-1:0] gray_q;
    logic             valid_q;
    logic [WIDTH-1:0] bin_d;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        logic acc;
        acc   = 1'b0;
        bin_d = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            acc      = acc ^ gray_q[i];
            bin_d[i] = acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_q    <= '0;
            valid_q   <= 1'b0;
            bin_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            gray_q    <= gray_in;
            valid_q   <= in_valid;
            out_valid <= valid_q;
            if (valid_q) begin
                bin_out <= bin_d;
            end
        end
    end

`ifdef GRAY_DEC_STEP_CHECK_EN
    // bin_out always holds the last decoded valid sample, so it doubles as the
    // previous-sample reference; have_prev_q qualifies it after reset.
    logic             have_prev_q;
    logic [WIDTH-1:0] delta;
    logic             up_d;
    logic             dn_d;
    logic             err_d;
    logic [ERR_W-1:0] cnt_d;

    always_comb begin
        delta = bin_d - bin_out;
        up_d  = 1'b0;
        dn_d  = 1'b0;
        err_d = 1'b0;
        if (valid_q && have_prev_q) begin
            if (delta == WIDTH'(1)) begin
                up_d = 1'b1;
            end else if (delta == '1) begin
                dn_d = 1'b1;
            end else if (delta != '0) begin
                err_d = 1'b1;
            end
        end
    end

    // Clear first, then count, so a simultaneous clear and error leaves 1.
    always_comb begin
        cnt_d = clr_err ? '0 : err_cnt;
        if (err_d && (cnt_d != '1)) begin
            cnt_d = cnt_d + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_prev_q <= 1'b0;
            dir_up      <= 1'b0;
            dir_dn      <= 1'b0;
            step_err    <= 1'b0;
            err_cnt     <= '0;
        end else begin
            dir_up   <= up_d;
            dir_dn   <= dn_d;
            step_err <= err_d;
            err_cnt  <= cnt_d;
            if (valid_q) begin
                have_prev_q <= 1'b1;
            end
        end
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign dir_up         = 1'b0;
    assign dir_dn         = 1'b0;
    assign step_err       = 1'b0;
    assign err_cnt        = '0;
`endif

endmodule
